// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b11
   } div_state_e;

   localparam int unsigned DIV_WIDTH = 16;
   localparam int unsigned CNT_W     = $clog2(DIV_WIDTH) + 1;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the accumulator left and trial-subtract the divisor.
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [2*WIDTH:0]  acu_i,
   input  logic [WIDTH-1:0]  dvs_i,
   output logic [2*WIDTH:0]  acu_o,
   output logic              qbit_o
);

   logic [2*WIDTH+1:0] s;
   logic [WIDTH+1:0]   t;

   // The top accumulator bit is kept in the subtraction so the sign test sees the full shifted remainder.
   always_comb begin
      s      = {acu_i, 1'b0};
      t      = s[2*WIDTH+1:WIDTH] - {2'b00, dvs_i};
      qbit_o = ~t[WIDTH+1];
      if (qbit_o) begin
         acu_o = {t[WIDTH:0], s[WIDTH-1:1], 1'b1};
      end else begin
         acu_o = s[2*WIDTH:0];
      end
   end

endmodule

// File: rtl/div_sec_16.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
module div_sec_16
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int unsigned     CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   div_state_e        state_q;
   logic [2*WIDTH:0]  acu_q;
   logic [2*WIDTH:0]  acu_d;
   logic [2*WIDTH:0]  step_acu;
   logic              step_qbit;
   logic [WIDTH-1:0]  dvs_q;
   logic [CW-1:0]     cnt_q;
   logic              done_q;
   logic              dz_q;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acu_i  (acu_q),
      .dvs_i  (dvs_q),
      .acu_o  (step_acu),
      .qbit_o (step_qbit)
   );

   always_comb begin
      acu_d = {step_acu[2*WIDTH:1], step_acu[0] | step_qbit};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acu_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (st) begin
                  dvs_q <= divisor;
                  cnt_q <= '0;
                  if (divisor == '0) begin
                     // Divide-by-zero skips iteration: quotient all ones, remainder is the dividend.
                     acu_q   <= {1'b0, dividend, {WIDTH{1'b1}}};
                     dz_q    <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     acu_q   <= {{(WIDTH+1){1'b0}}, dividend};
                     dz_q    <= 1'b0;
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               acu_q <= acu_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign done      = done_q;
   assign quotient  = acu_q[WIDTH-1:0];
   assign remainder = acu_q[2*WIDTH-1:WIDTH];
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_sec_16.sv
// Directed and random checks of div_sec_16: latency, results, div-by-zero, async reset, st handling.
module tb_div_sec_16;

   logic        clk = 1'b0;
   logic        rst;
   logic        st;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_zero;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   div_sec_16 #(
      .WIDTH (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .st        (st),
      .dividend  (dividend),
      .divisor   (divisor),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Presents operands with st for one edge; returns 1 ns after the capturing edge.
   task automatic start(input logic [15:0] a, input logic [15:0] b);
      dividend = a;
      divisor  = b;
      st       = 1'b1;
      @(posedge clk);
      #1;
      st = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eq, input logic [15:0] er, input logic edz, input int elat);
      int cyc;
      start(a, b);
      wait_done(cyc);
      check({tag, "/latency"}, cyc, elat);
      check({tag, "/quotient"}, quotient, eq);
      check({tag, "/remainder"}, remainder, er);
      check({tag, "/div_zero"}, div_zero, edz);
      @(posedge clk);
      #1;
      check({tag, "/done_one_cycle"}, done, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int seen;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] eq;
      logic [15:0] er;

      rst      = 1'b1;
      st       = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      check("reset/done", done, 0);
      check("reset/quotient", quotient, 0);
      check("reset/remainder", remainder, 0);
      check("reset/div_zero", div_zero, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic case, then results must hold while idle.
      run("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
      repeat (3) @(posedge clk);
      #1;
      check("hold/quotient", quotient, 16'd14);
      check("hold/remainder", remainder, 16'd2);

      run("FFFF/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16);
      run("FFFF/FFFF", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16);
      run("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 16);
      run("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 0);
      run("0/5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 16);

      // Async reset in the middle of an operation.
      start(16'd50000, 16'd3);
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst/done", done, 0);
      check("midrst/quotient", quotient, 0);
      check("midrst/remainder", remainder, 0);
      check("midrst/div_zero", div_zero, 0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      seen = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen++;
      end
      check("midrst/no_done", seen, 0);
      run("50000/3", 16'd50000, 16'd3, 16'd16666, 16'd2, 1'b0, 16);

      // A second st during CALC is ignored and operands may change after capture.
      start(16'd1000, 16'd10);
      repeat (3) @(posedge clk);
      #1;
      dividend = 16'd7;
      divisor  = 16'd2;
      st       = 1'b1;
      @(posedge clk);
      #1;
      st       = 1'b0;
      dividend = 16'h1234;
      divisor  = 16'd3;
      wait_done(cyc);
      check("ignore_st/latency", cyc, 12);
      check("ignore_st/quotient", quotient, 16'd100);
      check("ignore_st/remainder", remainder, 16'd0);
      seen = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen++;
      end
      check("ignore_st/no_extra_done", seen, 0);

      // st held high: back-to-back operations every 18 cycles.
      dividend = 16'd200;
      divisor  = 16'd9;
      st       = 1'b1;
      wait_done(cyc);
      check("b2b/first_latency", cyc, 17);
      check("b2b/q0", quotient, 16'd22);
      check("b2b/r0", remainder, 16'd2);
      for (int k = 0; k < 3; k++) begin
         if (k % 2 == 0) begin
            dividend = 16'd300;
            divisor  = 16'd7;
            eq = 16'd42;
            er = 16'd6;
         end else begin
            dividend = 16'd200;
            divisor  = 16'd9;
            eq = 16'd22;
            er = 16'd2;
         end
         @(posedge clk);
         #1;
         wait_done(cyc);
         check("b2b/period", cyc + 1, 18);
         check("b2b/quotient", quotient, eq);
         check("b2b/remainder", remainder, er);
      end
      st = 1'b0;
      @(posedge clk);
      #1;

      // Random vectors against the arithmetic reference.
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom);
         case (i % 4)
            0: b = 16'($urandom);
            1: b = 16'($urandom_range(1, 255));
            2: b = 16'($urandom_range(1, 16));
            default: b = 16'($urandom) | 16'h8000;
         endcase
         if (i % 50 == 7) b = 16'd0;
         if (b == 16'd0) begin
            run("rand_dz", a, b, 16'hFFFF, a, 1'b1, 0);
         end else begin
            eq = a / b;
            er = a % b;
            run("rand", a, b, eq, er, 1'b0, 16);
            check("rand/recon", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check("rand/rem_lt_div", (remainder < b) ? 32'd1 : 32'd0, 32'd1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
